// File: rtl/execute_stage.sv
// EX stage: ALU plus EX/MEM register clocked on negedge Clk; EX_MULDIV_EN adds a 32-step shift-add multiplier.
// Latency: 1 negedge for ALU ops, MUL result on the 34th negedge after issue.
// Backpressure: Stall (combinational) holds ID/IF during a multiply; Flush beats everything.
module execute_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_W-1:0]     ReadData1,
  input  logic [DATA_W-1:0]     ReadData2,
  input  logic [DATA_W-1:0]     Immediate,
  input  logic                  ALUSrc,
  input  logic [3:0]            ALUOp,
  input  logic [1:0]            WBControl,
  input  logic [1:0]            MEMControl,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  input  logic                  Flush,
  output logic [DATA_W-1:0]     Address,
  output logic [DATA_W-1:0]     Data,
  output logic [1:0]            WBControlOut,
  output logic [1:0]            MEMControlOut,
  output logic [REG_ADDR_W-1:0] WriteRegOut,
  output logic                  Zero,
  output logic                  Stall
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic [DATA_W-1:0]     w_b;
  logic [DATA_W-1:0]     w_alu;
  logic [DATA_W-1:0]     w_res;
  logic                  w_load;
  logic [DATA_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_wb;
  logic [1:0]            r_mem;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic                  r_zero;

  assign w_b = ALUSrc ? Immediate : ReadData2;

  // MUL falls into the default arm: it only produces a product through the iterative path.
  always_comb begin
    w_alu = '0;
    case (ALUOp)
      OP_AND:  w_alu = ReadData1 & w_b;
      OP_OR:   w_alu = ReadData1 | w_b;
      OP_ADD:  w_alu = ReadData1 + w_b;
      OP_XOR:  w_alu = ReadData1 ^ w_b;
      OP_SUB:  w_alu = ReadData1 - w_b;
      OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(ReadData1) < $signed(w_b))};
      OP_NOR:  w_alu = ~(ReadData1 | w_b);
      default: w_alu = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_mb;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_mul_op;

  assign w_mul_op = (ALUOp == OP_MUL);
  assign Stall    = Rst_n & w_mul_op & (r_state != S_DONE);
  assign w_load   = (r_state == S_DONE) || ((r_state == S_IDLE) && !w_mul_op);
  assign w_res    = (r_state == S_DONE) ? r_acc : w_alu;

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (Flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_op) begin
            r_a     <= ReadData1;
            r_mb    <= w_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_mb[r_cnt]) r_acc <= r_acc + (r_a << r_cnt);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W-1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign Stall  = 1'b0;
  assign w_load = 1'b1;
  assign w_res  = w_alu;
`endif

  // A bubble keeps the datapath fields and only kills the control bits.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_wb   <= '0;
      r_mem  <= '0;
      r_wreg <= '0;
      r_zero <= 1'b0;
    end else if (Flush || !w_load) begin
      r_wb   <= '0;
      r_mem  <= '0;
      r_zero <= 1'b0;
    end else begin
      r_addr <= w_res;
      r_data <= ReadData2;
      r_wb   <= WBControl;
      r_mem  <= MEMControl;
      r_wreg <= WriteReg;
      r_zero <= (w_res == '0);
    end
  end

  assign Address       = r_addr;
  assign Data          = r_data;
  assign WBControlOut  = r_wb;
  assign MEMControlOut = r_mem;
  assign WriteRegOut   = r_wreg;
  assign Zero          = r_zero;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed and random ALU ops against a plain-arithmetic model; multiply scenarios when EX_MULDIV_EN is defined.
module tb_execute_stage;
  logic        Clk;
  logic        Rst_n;
  logic [31:0] ReadData1, ReadData2, Immediate;
  logic        ALUSrc;
  logic [3:0]  ALUOp;
  logic [1:0]  WBControl, MEMControl;
  logic [4:0]  WriteReg;
  logic        Flush;
  logic [31:0] Address, Data;
  logic [1:0]  WBControlOut, MEMControlOut;
  logic [4:0]  WriteRegOut;
  logic        Zero, Stall;

  int checks = 0;
  int failures = 0;
  logic [31:0] e_addr, e_data;
  logic [4:0]  e_wreg;

  execute_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Immediate(Immediate), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .WBControl(WBControl),
    .MEMControl(MEMControl), .WriteReg(WriteReg), .Flush(Flush), .Address(Address),
    .Data(Data), .WBControlOut(WBControlOut), .MEMControlOut(MEMControlOut),
    .WriteRegOut(WriteRegOut), .Zero(Zero), .Stall(Stall)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
`ifdef EX_MULDIV_EN
      4'b1000: return a * b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [74:0] outs();
    return {Address, Data, WBControlOut, MEMControlOut, WriteRegOut, Zero, Stall};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic [1:0] wb,
                       input logic [1:0] mem, input logic [4:0] wr);
    ALUOp = op; ReadData1 = a; ReadData2 = b; Immediate = imm; ALUSrc = src;
    WBControl = wb; MEMControl = mem; WriteReg = wr;
  endtask

  task automatic tick();
    @(negedge Clk);
    @(posedge Clk);
  endtask

  task automatic test_reset();
    logic [74:0] exp;
    Rst_n = 1'b0; Flush = 1'b0;
    drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 5'd0);
    @(posedge Clk);
    checks++;
    if (outs() !== 75'd0) begin
      failures++; $display("FAIL reset_initial got=%h exp=0", outs());
    end
    Rst_n = 1'b1;
    drive(4'b0010, 32'd9, 32'd9, 32'd0, 1'b0, 2'b11, 2'b01, 5'd4);
    tick();
    checks++;
    exp = {32'd18, 32'd9, 2'b11, 2'b01, 5'd4, 1'b0, 1'b0};
    if (outs() !== exp) begin
      failures++; $display("FAIL pre_reset_add got=%h exp=%h", outs(), exp);
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 75'd0) begin
      failures++; $display("FAIL reset_midrun got=%h exp=0", outs());
    end
    @(posedge Clk);
    Rst_n = 1'b1;
    drive(4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 2'b01, 2'b10, 5'd3);
    tick();
    checks++;
    exp = {32'd12, 32'd7, 2'b01, 2'b10, 5'd3, 1'b0, 1'b0};
    if (outs() !== exp) begin
      failures++; $display("FAIL after_reset_add got=%h exp=%h", outs(), exp);
    end
    e_addr = 32'd12; e_data = 32'd7; e_wreg = 5'd3;
  endtask

  task automatic test_directed();
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic [74:0] exp;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin op = 4'b0110; a = 32'h10;       b = 32'h10; r = 32'd0; end
        1:       begin op = 4'b0111; a = 32'hFFFFFFFF; b = 32'd1;  r = 32'd1; end
        default: begin op = 4'b0010; a = 32'hFFFFFFFF; b = 32'd1;  r = 32'd0; end
      endcase
      drive(op, a, b, 32'hDEAD0000, 1'b0, 2'b10, 2'b01, 5'(i + 1));
      tick();
      checks++;
      exp = {r, b, 2'b10, 2'b01, 5'(i + 1), (r == 32'd0), 1'b0};
      if (outs() !== exp) begin
        failures++; $display("FAIL directed_%0d got=%h exp=%h", i, outs(), exp);
      end
      e_addr = r; e_data = b; e_wreg = 5'(i + 1);
    end
  endtask

  task automatic test_random_alu();
    logic [3:0]  op;
    logic [31:0] a, b, imm, r;
    logic        src;
    logic [1:0]  wb, mem;
    logic [4:0]  wr;
    logic [74:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
`ifdef EX_MULDIV_EN
      if (op == 4'b1000) op = 4'b0110;
`endif
      a = $urandom; b = $urandom; imm = $urandom;
      if (i % 5 == 0) b = a;
      src = 1'($urandom); wb = 2'($urandom); mem = 2'($urandom); wr = 5'($urandom);
      drive(op, a, b, imm, src, wb, mem, wr);
      r = ref_alu(op, a, src ? imm : b);
      tick();
      checks++;
      exp = {r, b, wb, mem, wr, (r == 32'd0), 1'b0};
      if (outs() !== exp) begin
        failures++; $display("FAIL random_op%0h iter%0d got=%h exp=%h", op, i, outs(), exp);
      end
      e_addr = r; e_data = b; e_wreg = wr;
    end
  endtask

  task automatic test_flush();
    logic [74:0] exp;
    Flush = 1'b1;
    drive(4'b0010, 32'h1111, 32'h2222, 32'd0, 1'b0, 2'b11, 2'b11, 5'd30);
    tick();
    Flush = 1'b0;
    checks++;
    exp = {e_addr, e_data, 2'b00, 2'b00, e_wreg, 1'b0, 1'b0};
    if (outs() !== exp) begin
      failures++; $display("FAIL flush_bubble got=%h exp=%h", outs(), exp);
    end
  endtask

`ifdef EX_MULDIV_EN
  task automatic test_mul();
    int stall_hi, bubbles;
    logic [31:0] a, b;
    logic [74:0] exp;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 32'h1234 : $urandom;
      b = (k == 0) ? 32'h10 : $urandom;
      drive(4'b1000, a, b, 32'hFFFF, 1'b0, 2'b10, 2'b01, 5'(7 + k));
      stall_hi = 0; bubbles = 0;
      for (int n = 1; n <= 33; n++) begin
        if (Stall === 1'b1) stall_hi++;
        tick();
        if (WBControlOut === 2'b00 && MEMControlOut === 2'b00 && Zero === 1'b0 && Address === e_addr) bubbles++;
      end
      checks++;
      if (stall_hi != 33) begin
        failures++; $display("FAIL mul%0d_stall_count got=%0d exp=33", k, stall_hi);
      end
      checks++;
      if (bubbles != 33) begin
        failures++; $display("FAIL mul%0d_bubble_count got=%0d exp=33", k, bubbles);
      end
      checks++;
      if (Stall !== 1'b0) begin
        failures++; $display("FAIL mul%0d_stall_done got=%b exp=0", k, Stall);
      end
      tick();
      exp = {a * b, b, 2'b10, 2'b01, 5'(7 + k), ((a * b) == 32'd0), 1'b1};
      checks++;
      if (outs() !== exp) begin
        failures++; $display("FAIL mul%0d_result got=%h exp=%h", k, outs(), exp);
      end
      e_addr = a * b; e_data = b; e_wreg = 5'(7 + k);
      drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, e_wreg);
      tick();
      e_addr = 32'd0; e_data = 32'd0;
    end
  endtask

  task automatic test_mul_flush();
    logic [74:0] exp;
    drive(4'b1000, 32'h0000_0F0F, 32'h0000_0101, 32'd0, 1'b0, 2'b11, 2'b11, 5'd12);
    for (int n = 1; n <= 9; n++) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    drive(4'b0000, 32'hF0, 32'h3C, 32'd0, 1'b0, 2'b01, 2'b00, 5'd13);
    checks++;
    exp = {e_addr, e_data, 2'b00, 2'b00, e_wreg, 1'b0, 1'b0};
    if (outs() !== exp) begin
      failures++; $display("FAIL mul_flush_bubble got=%h exp=%h", outs(), exp);
    end
    tick();
    checks++;
    exp = {32'h30, 32'h3C, 2'b01, 2'b00, 5'd13, 1'b0, 1'b0};
    if (outs() !== exp) begin
      failures++; $display("FAIL mul_flush_next got=%h exp=%h", outs(), exp);
    end
    e_addr = 32'h30; e_data = 32'h3C; e_wreg = 5'd13;
  endtask

  task automatic test_mul_reset();
    logic [74:0] exp;
    drive(4'b1000, 32'h0001_0003, 32'h0000_0707, 32'd0, 1'b0, 2'b11, 2'b10, 5'd20);
    for (int n = 1; n <= 19; n++) tick();
    Rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 75'd0) begin
      failures++; $display("FAIL mul_reset_outputs got=%h exp=0", outs());
    end
    drive(4'b0010, 32'd100, 32'd23, 32'd0, 1'b0, 2'b01, 2'b01, 5'd21);
    @(posedge Clk);
    Rst_n = 1'b1;
    tick();
    checks++;
    exp = {32'd123, 32'd23, 2'b01, 2'b01, 5'd21, 1'b0, 1'b0};
    if (outs() !== exp) begin
      failures++; $display("FAIL mul_reset_next_add got=%h exp=%h", outs(), exp);
    end
    e_addr = 32'd123; e_data = 32'd23; e_wreg = 5'd21;
  endtask
`else
  task automatic test_mul_disabled();
    logic [74:0] exp;
    drive(4'b1000, 32'd3, 32'd4, 32'd0, 1'b0, 2'b11, 2'b10, 5'd9);
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      failures++; $display("FAIL mul_disabled_stall got=%b exp=0", Stall);
    end
    tick();
    checks++;
    exp = {32'd0, 32'd4, 2'b11, 2'b10, 5'd9, 1'b1, 1'b0};
    if (outs() !== exp) begin
      failures++; $display("FAIL mul_disabled_result got=%h exp=%h", outs(), exp);
    end
    e_addr = 32'd0; e_data = 32'd4; e_wreg = 5'd9;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random_alu();
    test_flush();
`ifdef EX_MULDIV_EN
    test_mul();
    test_mul_flush();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_random_alu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
